// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helpers for the sequential divider
package div_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/cla_sub.sv
// cla_sub: N-bit subtractor a - b = a + ~b + 1 built from chained 4-bit lookahead groups
module cla_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);
  localparam int G = (N + 3) / 4;
  localparam int M = 4 * G;
  logic [M-1:0] a_p, b_n, s;
  logic [G:0] c;
  assign a_p = M'(a);
  assign b_n = ~(M'(b));
  assign c[0] = 1'b1;
  for (genvar i = 0; i < G; i++) begin : g_grp
    logic [3:0] gg, pp;
    logic [4:0] cc;
    assign gg = a_p[4*i +: 4] & b_n[4*i +: 4];
    assign pp = a_p[4*i +: 4] ^ b_n[4*i +: 4];
    assign cc[0] = c[i];
    assign cc[1] = gg[0] | (pp[0] & cc[0]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (&pp[1:0] & cc[0]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (&pp[2:1] & gg[0]) | (&pp[2:0] & cc[0]);
    assign cc[4] = gg[3] | (pp[3] & gg[2]) | (&pp[3:2] & gg[1]) | (&pp[3:1] & gg[0]) | (&pp & cc[0]);
    assign s[4*i +: 4] = pp ^ cc[3:0];
    assign c[i+1] = cc[4];
  end
  assign diff = s[N-1:0];
  // pad sum bits all equal ~carry, so folding them in leaves the carry unchanged
  if (M > N) begin : g_pad
    assign cout = c[G] & ~|s[M-1:N];
  end else begin : g_nopad
    assign cout = c[G];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] r, r_sh, trial, r_nxt;
  logic [WIDTH-1:0] q, q_nxt, dvs;
  logic no_borrow, zero;
  assign r_sh = (r << 1) | (WIDTH+1)'(q[WIDTH-1]);
  cla_sub #(.N(WIDTH + 1)) u_sub (
    .a(r_sh),
    .b({1'b0, dvs}),
    .diff(trial),
    .cout(no_borrow)
  );
  assign r_nxt = no_borrow ? trial : r_sh;
  assign q_nxt = (q << 1) | WIDTH'(no_borrow);
  assign zero = ~|dvs;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // a zero divisor spends one RUN cycle with Q still holding the dividend, then reports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        dvs <= divisor;
        r <= '0;
        q <= dividend;
        cnt <= CW'(WIDTH);
        state <= RUN;
      end
    end else if (state == RUN) begin
      r <= r_nxt;
      q <= q_nxt;
      cnt <= cnt - CW'(1);
      if (zero || cnt == CW'(1)) begin
        state <= DONE;
        quotient <= zero ? DBZ_QUOTIENT[WIDTH-1:0] : q_nxt;
        remainder <= zero ? q : r_nxt[WIDTH-1:0];
        div_by_zero <= zero;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
